// File: rtl/pwm_preconditioner.sv
// Converts per-transducer duty/phase/cycle into PWM rise/fall edge times.
// One element per clock through a 3-stage pipeline into a shadow buffer, committed atomically.
module pwm_preconditioner #(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned DEPTH = 249
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             DIN_VALID,
  input  logic [WIDTH-1:0] CYCLE [DEPTH],
  input  logic [WIDTH-1:0] DUTY  [DEPTH],
  input  logic [WIDTH-1:0] PHASE [DEPTH],
  output logic [WIDTH-1:0] RISE  [DEPTH],
  output logic [WIDTH-1:0] FALL  [DEPTH],
  output logic             DOUT_VALID
);

  localparam int unsigned IdxW = $clog2(DEPTH + 1);
  // Two guard bits keep phase + ceil(duty/2) and phase - floor(duty/2) exact.
  localparam int unsigned AccW = WIDTH + 2;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);
  localparam logic [IdxW-1:0] NumIdx  = IdxW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StCommit} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q;
  logic            start, issue, commit, last_write;

  // Stage 1: sampled operands
  logic             s1_valid_q;
  logic [IdxW-1:0]  s1_idx_q;
  logic [WIDTH-1:0] s1_cycle_q, s1_duty_q, s1_phase_q;

  // Stage 2: raw edges plus special-case flags
  logic                   s2_valid_q;
  logic [IdxW-1:0]        s2_idx_q;
  logic [WIDTH-1:0]       s2_cycle_q;
  logic                   s2_zero_q, s2_full_q;
  logic signed [AccW-1:0] s2_r_q, s2_f_q;

  logic signed [AccW-1:0] duty_x, phase_x, half_x, rest_x, r_raw, f_raw;
  logic signed [AccW-1:0] cycle_x, r_fix, f_fix;
  logic [WIDTH-1:0]       rise_new, fall_new;

  logic [WIDTH-1:0] rise_buf_q [DEPTH];
  logic [WIDTH-1:0] fall_buf_q [DEPTH];

  // ---------------------------------------------------------------- control FSM
  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    issue      = 1'b0;
    commit     = 1'b0;
    last_write = s2_valid_q && (s2_idx_q == LastIdx);
    unique case (state_q)
      StIdle: begin
        if (DIN_VALID) begin
          start   = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        issue = (idx_q < NumIdx);
        if (last_write) state_d = StCommit;
      end
      StCommit: begin
        commit  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        idx_q <= '0;
      end else if (issue) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- stage 1
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      s1_cycle_q <= '0;
      s1_duty_q  <= '0;
      s1_phase_q <= '0;
    end else begin
      s1_valid_q <= issue;
      if (issue) begin
        s1_idx_q   <= idx_q;
        s1_cycle_q <= CYCLE[idx_q];
        s1_duty_q  <= DUTY[idx_q];
        s1_phase_q <= PHASE[idx_q];
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  always_comb begin
    duty_x  = $signed({2'b00, s1_duty_q});
    phase_x = $signed({2'b00, s1_phase_q});
    half_x  = duty_x >>> 1;
    rest_x  = duty_x - half_x;
    r_raw   = phase_x - half_x;
    f_raw   = phase_x + rest_x;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s2_valid_q <= 1'b0;
      s2_idx_q   <= '0;
      s2_cycle_q <= '0;
      s2_zero_q  <= 1'b0;
      s2_full_q  <= 1'b0;
      s2_r_q     <= '0;
      s2_f_q     <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_idx_q   <= s1_idx_q;
        s2_cycle_q <= s1_cycle_q;
        s2_zero_q  <= (s1_duty_q == '0);
        s2_full_q  <= (s1_duty_q >= s1_cycle_q);
        s2_r_q     <= r_raw;
        s2_f_q     <= f_raw;
      end
    end
  end

  // ---------------------------------------------------------------- stage 3
  // Single wrap correction only; out-of-range phase gives a deterministic truncation.
  always_comb begin
    cycle_x  = $signed({2'b00, s2_cycle_q});
    r_fix    = (s2_r_q < 0) ? (s2_r_q + cycle_x) : s2_r_q;
    f_fix    = (s2_f_q >= cycle_x) ? (s2_f_q - cycle_x) : s2_f_q;
    rise_new = WIDTH'(r_fix);
    fall_new = WIDTH'(f_fix);
    if (s2_zero_q) begin
      rise_new = '0;
      fall_new = '0;
    end else if (s2_full_q) begin
      rise_new = '0;
      fall_new = s2_cycle_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rise_buf_q <= '{default: '0};
      fall_buf_q <= '{default: '0};
    end else if (s2_valid_q) begin
      rise_buf_q[s2_idx_q] <= rise_new;
      fall_buf_q[s2_idx_q] <= fall_new;
    end
  end

  // ---------------------------------------------------------------- commit
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RISE       <= '{default: '0};
      FALL       <= '{default: '0};
      DOUT_VALID <= 1'b0;
    end else begin
      DOUT_VALID <= commit;
      if (commit) begin
        RISE <= rise_buf_q;
        FALL <= fall_buf_q;
      end
    end
  end

endmodule

// File: tb/tb_pwm_preconditioner.sv
// Directed and randomized checks for pwm_preconditioner: latency, edge math, atomic commit, reset.
module tb_pwm_preconditioner;

  localparam int W = 13;
  localparam int D = 249;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         din_valid = 1'b0;
  logic [W-1:0] cycle [D];
  logic [W-1:0] duty  [D];
  logic [W-1:0] phase [D];
  logic [W-1:0] rise  [D];
  logic [W-1:0] fall  [D];
  logic         dout_valid;

  int checks = 0;
  int errors = 0;
  int exp_r [D];
  int exp_f [D];

  always #5 clk = ~clk;

  pwm_preconditioner #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .DIN_VALID (din_valid),
    .CYCLE     (cycle),
    .DUTY      (duty),
    .PHASE     (phase),
    .RISE      (rise),
    .FALL      (fall),
    .DOUT_VALID(dout_valid)
  );

  task automatic fill(input int c, input int d, input int p);
    for (int i = 0; i < D; i++) begin
      cycle[i] = 13'(c);
      duty[i]  = 13'(d);
      phase[i] = 13'(p);
    end
  endtask

  task automatic set_elem(input int i, input int c, input int d, input int p);
    cycle[i] = 13'(c);
    duty[i]  = 13'(d);
    phase[i] = 13'(p);
  endtask

  // Pulse DIN_VALID into edge e0, then watch 256 edges for DOUT_VALID.
  task automatic start_and_watch(output int lat, output int pulses);
    lat    = -1;
    pulses = 0;
    din_valid = 1'b1;
    @(posedge clk);
    #1 din_valid = 1'b0;
    for (int n = 1; n <= 256; n++) begin
      @(posedge clk);
      #1;
      if (dout_valid) begin
        pulses++;
        if (lat < 0) lat = n;
      end
    end
  endtask

  function automatic void model(input int c, input int d, input int p, output int r, output int f);
    int h, g;
    if (d == 0) begin
      r = 0; f = 0;
    end else if (d >= c) begin
      r = 0; f = c;
    end else begin
      h = d / 2;
      g = d - h;
      r = p - h;
      if (r < 0) r += c;
      f = p + g;
      if (f >= c) f -= c;
    end
  endfunction

  task automatic test_reset();
    fill(0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_dout_valid got %0b want 0", dout_valid);
    end
    for (int i = 0; i < D; i++) begin
      checks++;
      if (rise[i] !== 13'd0 || fall[i] !== 13'd0) begin
        errors++;
        $display("FAIL reset_edges[%0d] got %0d/%0d want 0/0", i, rise[i], fall[i]);
      end
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int lat, pulses;
    fill(4096, 2048, 2048);
    start_and_watch(lat, pulses);
    checks++;
    if (lat !== 252) begin
      errors++;
      $display("FAIL basic_latency got %0d want 252", lat);
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL basic_pulses got %0d want 1", pulses);
    end
    for (int i = 0; i < D; i++) begin
      checks++;
      if (rise[i] !== 13'd1024 || fall[i] !== 13'd3072) begin
        errors++;
        $display("FAIL basic_edges[%0d] got %0d/%0d want 1024/3072", i, rise[i], fall[i]);
      end
    end
  endtask

  task automatic test_wrap_special();
    int lat, pulses;
    int wr [7];
    int wf [7];
    wr = '{3596, 3850, 1998, 0, 0, 0, 1024};
    wf = '{500, 55, 0, 0, 4096, 4096, 3072};
    fill(4096, 2048, 2048);
    set_elem(0, 4096, 1000, 0);
    set_elem(1, 4096, 301, 4000);
    set_elem(2, 2000, 2, 1999);
    set_elem(3, 4096, 0, 123);
    set_elem(4, 4096, 4096, 7);
    set_elem(5, 4096, 5000, 7);
    start_and_watch(lat, pulses);
    checks++;
    if (lat !== 252 || pulses !== 1) begin
      errors++;
      $display("FAIL wrap_latency got %0d (pulses %0d) want 252 (1)", lat, pulses);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (rise[i] !== 13'(wr[i]) || fall[i] !== 13'(wf[i])) begin
        errors++;
        $display("FAIL wrap_edges[%0d] got %0d/%0d want %0d/%0d", i, rise[i], fall[i], wr[i], wf[i]);
      end
    end
  endtask

  // Starts from the wrap test's committed outputs: elem0 3596/500, elem1 3850/55, elem248 1024/3072.
  task automatic test_atomicity();
    int lat, pulses, hold_bad;
    fill(4096, 2048, 2048);
    set_elem(0, 4096, 200, 300);
    set_elem(248, 4096, 2048, 1000);
    lat      = -1;
    hold_bad = 0;
    din_valid = 1'b1;
    @(posedge clk);
    #1 din_valid = 1'b0;
    for (int n = 1; n <= 300 && lat < 0; n++) begin
      if (n == 10) duty[0] = 13'd0;
      if (n == 50) din_valid = 1'b1;
      @(posedge clk);
      #1 din_valid = 1'b0;
      if (dout_valid) begin
        lat = n;
      end else if (rise[0] !== 13'd3596 || fall[0] !== 13'd500 || rise[1] !== 13'd3850 ||
                   rise[248] !== 13'd1024 || fall[248] !== 13'd3072) begin
        hold_bad++;
      end
    end
    checks++;
    if (lat !== 252) begin
      errors++;
      $display("FAIL atomic_latency got %0d want 252", lat);
    end
    checks++;
    if (hold_bad !== 0) begin
      errors++;
      $display("FAIL atomic_hold got %0d early-change cycles want 0", hold_bad);
    end
    checks++;
    if (rise[0] !== 13'd200 || fall[0] !== 13'd400) begin
      errors++;
      $display("FAIL atomic_elem0 got %0d/%0d want 200/400", rise[0], fall[0]);
    end
    checks++;
    if (rise[1] !== 13'd1024 || fall[1] !== 13'd3072) begin
      errors++;
      $display("FAIL atomic_elem1 got %0d/%0d want 1024/3072", rise[1], fall[1]);
    end
    checks++;
    if (rise[248] !== 13'd4072 || fall[248] !== 13'd2024) begin
      errors++;
      $display("FAIL atomic_elem248 got %0d/%0d want 4072/2024", rise[248], fall[248]);
    end
    test_back_to_back();
  endtask

  // Entered #1 after the commit edge e(DEPTH+3); next edge is e(DEPTH+4).
  task automatic test_back_to_back();
    int lat, pulses;
    lat    = -1;
    pulses = 0;
    din_valid = 1'b1;
    @(posedge clk);
    #1 din_valid = 1'b0;
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_pulse_width got %0b want 0", dout_valid);
    end
    for (int n = 1; n <= 256; n++) begin
      @(posedge clk);
      #1;
      if (dout_valid) begin
        pulses++;
        if (lat < 0) lat = n;
      end
    end
    checks++;
    if (lat !== 252 || pulses !== 1) begin
      errors++;
      $display("FAIL b2b_latency got %0d (pulses %0d) want 252 (1)", lat, pulses);
    end
    checks++;
    if (rise[0] !== 13'd0 || fall[0] !== 13'd0) begin
      errors++;
      $display("FAIL b2b_elem0 got %0d/%0d want 0/0", rise[0], fall[0]);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, pulses;
    fill(4096, 2048, 2048);
    start_and_watch(lat, pulses);
    checks++;
    if (rise[0] !== 13'd1024) begin
      errors++;
      $display("FAIL midrst_precommit got %0d want 1024", rise[0]);
    end
    din_valid = 1'b1;
    @(posedge clk);
    #1 din_valid = 1'b0;
    repeat (99) @(posedge clk);
    #2 rst = 1'b1;
    #2;
    checks++;
    if (rise[0] !== 13'd0 || fall[0] !== 13'd0 || rise[248] !== 13'd0 || fall[248] !== 13'd0) begin
      errors++;
      $display("FAIL midrst_clear got %0d/%0d %0d/%0d want 0/0 0/0", rise[0], fall[0], rise[248],
               fall[248]);
    end
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_dout got %0b want 0", dout_valid);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    pulses = 0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      #1;
      if (dout_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL midrst_aborted_commit got %0d pulses want 0", pulses);
    end
    start_and_watch(lat, pulses);
    checks++;
    if (lat !== 252 || pulses !== 1) begin
      errors++;
      $display("FAIL midrst_recover got %0d (pulses %0d) want 252 (1)", lat, pulses);
    end
    checks++;
    if (rise[0] !== 13'd1024 || fall[248] !== 13'd3072) begin
      errors++;
      $display("FAIL midrst_recover_edges got %0d/%0d want 1024/3072", rise[0], fall[248]);
    end
  endtask

  task automatic test_random();
    int lat, pulses, c, d, p, r, f;
    for (int run = 0; run < 20; run++) begin
      for (int i = 0; i < D; i++) begin
        c = int'($urandom_range(8191, 2));
        d = int'($urandom_range(c, 0));
        p = int'($urandom_range(c - 1, 0));
        set_elem(i, c, d, p);
        model(c, d, p, r, f);
        exp_r[i] = r;
        exp_f[i] = f;
      end
      start_and_watch(lat, pulses);
      checks++;
      if (lat !== 252 || pulses !== 1) begin
        errors++;
        $display("FAIL rand_latency run %0d got %0d (pulses %0d) want 252 (1)", run, lat, pulses);
      end
      for (int i = 0; i < D; i++) begin
        checks++;
        if (rise[i] !== 13'(exp_r[i]) || fall[i] !== 13'(exp_f[i])) begin
          errors++;
          $display("FAIL rand_edges run %0d [%0d] c=%0d d=%0d p=%0d got %0d/%0d want %0d/%0d",
                   run, i, cycle[i], duty[i], phase[i], rise[i], fall[i], exp_r[i], exp_f[i]);
        end
        checks++;
        if (!(rise[i] < cycle[i] && fall[i] <= cycle[i])) begin
          errors++;
          $display("FAIL rand_range run %0d [%0d] got %0d/%0d want <%0d/<=%0d", run, i, rise[i],
                   fall[i], cycle[i], cycle[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap_special();
    test_atomicity();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
